// File: rtl/store_write_buffer_pkg.sv
// Shared types for the store write buffer: queued entry layout and drain FSM states.
package store_buf_pkg;

   localparam int SBUF_DEPTH = 4;
   localparam int WORD_W     = 30;

   typedef struct packed {
      logic [WORD_W-1:0] word_addr;
      logic [3:0]        byteen;
      logic [31:0]       data;
   } sbuf_entry_t;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } drain_state_e;

endpackage

// File: rtl/store_write_buffer_entry_match.sv
// Per-entry load lookup: word compare gated by entry validity, then per-lane select.
module sbuf_entry_match
   import store_buf_pkg::*;
(
   input  logic              valid,
   input  logic [WORD_W-1:0] word_addr,
   input  logic [3:0]        byteen,
   input  logic [WORD_W-1:0] ld_word,
   input  logic [3:0]        need,
   output logic [3:0]        lane_hit
);

   logic word_eq;

   assign word_eq  = valid & (word_addr == ld_word);
   assign lane_hit = {4{word_eq}} & byteen & need;

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: FIFO of aligned stores drained to memory over req/ack,
// with load hazard detection (or byte forwarding when STORE_LOAD_FWD_EN is defined).
module store_write_buffer
   import store_buf_pkg::*;
#(
   parameter int DEPTH = SBUF_DEPTH,
   parameter int AW    = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     st_valid,
   input  logic [AW-1:0]            st_addr,
   input  logic [3:0]               st_byteen,
   input  logic [31:0]              st_wdata,
   output logic                     st_stall,
   input  logic                     ld_valid,
   input  logic [AW-1:0]            ld_addr,
   input  logic [3:0]               ld_byteen,
   output logic                     ld_hazard,
   input  logic                     drain_req,
   output logic                     drain_busy,
   output logic                     mem_req,
   output logic [AW-1:0]            mem_addr,
   output logic [3:0]               mem_byteen,
   output logic [31:0]              mem_wdata,
   input  logic                     mem_ack,
   output logic [$clog2(DEPTH):0]   count,
   output drain_state_e             drain_state
`ifdef STORE_LOAD_FWD_EN
   ,
   output logic [31:0]              ld_fwd_data,
   output logic [3:0]               ld_fwd_mask
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]     head, tail;
   logic [DEPTH-1:0]  vld;
   sbuf_entry_t       ent [DEPTH];
   drain_state_e      state, state_nxt;
   logic              empty, full, draining, enq, deq;
   logic [WORD_W-1:0] ld_word;
   logic [3:0]        need_lanes;
   logic [3:0]        lane_hit [DEPTH];

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign draining = (state == DRAIN);
   // A same-cycle ack frees a slot only from the next edge, so stall depends on registered count alone.
   assign enq      = st_valid & (|st_byteen) & ~full & ~draining;
   assign deq      = ~empty & mem_ack;

   assign st_stall    = st_valid & (((|st_byteen) & full) | draining);
   assign drain_busy  = draining;
   assign drain_state = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         vld   <= '0;
         state <= IDLE;
      end else begin
         state <= state_nxt;
         if (deq) begin
            head      <= head + 1'b1;
            vld[head] <= 1'b0;
         end
         if (enq) begin
            tail      <= tail + 1'b1;
            vld[tail] <= 1'b1;
         end
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         ent[tail] <= '{word_addr: WORD_W'(st_addr[AW-1:2]), byteen: st_byteen, data: st_wdata};
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (drain_req && !empty) state_nxt = DRAIN;
         DRAIN: if (empty) state_nxt = IDLE;
      endcase
   end

   assign mem_req    = ~empty;
   assign mem_addr   = mem_req ? AW'({ent[head].word_addr, 2'b00}) : '0;
   assign mem_byteen = mem_req ? ent[head].byteen : 4'b0000;
   assign mem_wdata  = mem_req ? ent[head].data : 32'h0;

   assign ld_word = WORD_W'(ld_addr[AW-1:2]);

   for (genvar g = 0; g < DEPTH; g++) begin : g_match
      sbuf_entry_match u_match (
         .valid     (vld[g]),
         .word_addr (ent[g].word_addr),
         .byteen    (ent[g].byteen),
         .ld_word   (ld_word),
         .need      (need_lanes),
         .lane_hit  (lane_hit[g])
      );
   end

`ifdef STORE_LOAD_FWD_EN
   logic [PW-1:0] idx;
   logic          unused_bits;

   assign need_lanes  = 4'hF;
   assign ld_hazard   = 1'b0;
   assign unused_bits = ^{st_addr[1:0], ld_addr[1:0], ld_byteen};

   // Walk oldest to youngest so the youngest matching entry wins each lane.
   always_comb begin
      idx         = head;
      ld_fwd_data = 32'h0;
      ld_fwd_mask = 4'b0000;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         for (int b = 0; b < 4; b++) begin
            if (ld_valid && lane_hit[idx][b]) begin
               ld_fwd_data[8*b +: 8] = ent[idx].data[8*b +: 8];
               ld_fwd_mask[b]        = 1'b1;
            end
         end
      end
   end
`else
   logic any_hit;
   logic unused_bits;

   assign need_lanes  = ld_byteen;
   assign unused_bits = ^{st_addr[1:0], ld_addr[1:0]};

   always_comb begin
      any_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         any_hit = any_hit | (|lane_hit[i]);
      end
   end

   assign ld_hazard = ld_valid & any_hit;
`endif

endmodule
